// File: rtl/bmem_line_adapter.sv
// bmem_line_adapter: arbitrates I/D cache line requests onto 4-beat bmem bursts
// and reassembles returning read bursts into full lines by address match.
module bmem_line_adapter #(
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req,
    input  logic [31:0]               i_addr,
    output logic                      i_resp,
    output logic [BEAT_W*BEATS-1:0]   i_rdata,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [31:0]               d_addr,
    input  logic [BEAT_W*BEATS-1:0]   d_wdata,
    output logic                      d_resp,
    output logic [BEAT_W*BEATS-1:0]   d_rdata,
    output logic [31:0]               bmem_addr,
    output logic                      bmem_read,
    output logic                      bmem_write,
    output logic [BEAT_W-1:0]         bmem_wdata,
    input  logic                      bmem_ready,
    input  logic [31:0]               bmem_raddr,
    input  logic [BEAT_W-1:0]         bmem_rdata,
    input  logic                      bmem_rvalid
);
    localparam int LW = BEAT_W * BEATS;
    localparam int CW = $clog2(BEATS);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic {IDLE, WR} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic            rr_q, rr_d, own_q, own_d;
    logic            i_pend_q, i_pend_d, d_pend_q, d_pend_d;
    logic [31:0]     i_aq_q, i_aq_d, d_aq_q, d_aq_d;
    logic [LW-1:0]   buf_q, buf_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic            i_resp_q, i_resp_d, d_resp_q, d_resp_d;

    logic [31:0] i_line, d_line;
    logic        i_el, d_el, pick_d, issue, wr_issue, accept;
    logic        i_hit, d_hit, owner, take;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{i_addr[4:0], d_addr[4:0]};
    assign i_line   = {i_addr[31:5], 5'b0};
    assign d_line   = {d_addr[31:5], 5'b0};
    assign i_el     = i_req & ~i_pend_q & ~i_resp_q;
    assign d_el     = d_req & ~d_pend_q & ~d_resp_q;
    assign pick_d   = d_el & (~i_el | rr_q);
    assign issue    = (state_q == IDLE) & (i_el | d_el);
    assign wr_issue = issue & pick_d & d_we;
    assign accept   = issue & bmem_ready;
    // Owner is resolved on beat 0 only; D wins when both wait on the same line.
    assign d_hit    = d_pend_q & (bmem_raddr == d_aq_q);
    assign i_hit    = i_pend_q & (bmem_raddr == i_aq_q);
    assign owner    = (rcnt_q == '0) ? d_hit : own_q;
    assign take     = bmem_rvalid & ((rcnt_q != '0) | d_hit | i_hit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            rr_q      <= 1'b0;
            own_q     <= 1'b0;
            i_pend_q  <= 1'b0;
            d_pend_q  <= 1'b0;
            i_aq_q    <= '0;
            d_aq_q    <= '0;
            buf_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_resp_q  <= 1'b0;
            d_resp_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            rr_q      <= rr_d;
            own_q     <= own_d;
            i_pend_q  <= i_pend_d;
            d_pend_q  <= d_pend_d;
            i_aq_q    <= i_aq_d;
            d_aq_q    <= d_aq_d;
            buf_q     <= buf_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_resp_q  <= i_resp_d;
            d_resp_q  <= d_resp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        rr_d      = rr_q;
        own_d     = own_q;
        i_pend_d  = i_pend_q;
        d_pend_d  = d_pend_q;
        i_aq_d    = i_aq_q;
        d_aq_d    = d_aq_q;
        buf_d     = buf_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_resp_d  = 1'b0;
        d_resp_d  = 1'b0;
        if (accept) begin
            rr_d = ~rr_q;
            if (wr_issue) begin
                state_d = WR;
                wcnt_d  = CW'(1);
            end else if (pick_d) begin
                d_pend_d = 1'b1;
                d_aq_d   = d_line;
            end else begin
                i_pend_d = 1'b1;
                i_aq_d   = i_line;
            end
        end
        if (state_q == WR && bmem_ready) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == LAST) begin
                state_d  = IDLE;
                d_resp_d = 1'b1;
            end
        end
        if (take) begin
            buf_d[rcnt_q*BEAT_W +: BEAT_W] = bmem_rdata;
            rcnt_d = rcnt_q + 1'b1;
            own_d  = owner;
            if (rcnt_q == LAST) begin
                if (owner) begin
                    d_pend_d  = 1'b0;
                    d_rdata_d = buf_d;
                    d_resp_d  = 1'b1;
                end else begin
                    i_pend_d  = 1'b0;
                    i_rdata_d = buf_d;
                    i_resp_d  = 1'b1;
                end
            end
        end
    end

    // Issue outputs are combinational, so they are forced low while reset is held.
    always_comb begin
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        if (rst) begin
            if (state_q == WR) begin
                bmem_write = 1'b1;
                bmem_addr  = d_line;
                bmem_wdata = d_wdata[wcnt_q*BEAT_W +: BEAT_W];
            end else if (issue) begin
                bmem_read  = ~wr_issue;
                bmem_write = wr_issue;
                bmem_addr  = pick_d ? d_line : i_line;
                bmem_wdata = wr_issue ? d_wdata[wcnt_q*BEAT_W +: BEAT_W] : '0;
            end
        end
    end

    assign i_resp  = i_resp_q;
    assign d_resp  = d_resp_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
endmodule

// File: tb/tb_bmem_line_adapter.sv
// tb_bmem_line_adapter: directed checks of arbitration, write bursts, read
// reassembly/routing, stray beats and asynchronous reset.
module tb_bmem_line_adapter;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0]  i_addr = '0, d_addr = '0;
    logic [255:0] d_wdata = '0;
    logic         i_resp, d_resp;
    logic [255:0] i_rdata, d_rdata;
    logic [31:0]  bmem_addr;
    logic         bmem_read, bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready = 1'b0;
    logic [31:0]  bmem_raddr = '0;
    logic [63:0]  bmem_rdata = '0;
    logic         bmem_rvalid = 1'b0;
    int passed = 0;
    int total = 0;

    bmem_line_adapter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] line(input logic [63:0] b);
        logic [63:0] b1, b2, b3;
        b1 = b + 64'd1;
        b2 = b + 64'd2;
        b3 = b + 64'd3;
        return {b3, b2, b1, b};
    endfunction

    task automatic burst(input logic [31:0] a, input logic [63:0] base);
        for (int k = 0; k < 4; k++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = a;
            bmem_rdata  = base + 64'(k);
            cyc();
        end
        bmem_rvalid = 1'b0;
    endtask

    initial begin
        int rdy [6] = '{1, 0, 1, 1, 0, 1};
        int bt  [6] = '{0, 1, 1, 2, 3, 3};
        int acc = 0;
        // reset state, even with a request pending
        i_req = 1'b1; i_addr = 32'h1000;
        #1;
        chk("rst_read", bmem_read, 0);
        chk("rst_write", bmem_write, 0);
        chk("rst_addr", bmem_addr, 0);
        chk("rst_wdata", bmem_wdata, 0);
        chk("rst_iresp", i_resp, 0);
        chk("rst_dresp", d_resp, 0);
        chk("rst_irdata", i_rdata, 0);
        chk("rst_drdata", d_rdata, 0);
        i_req = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        // single I read, low address bits ignored
        i_req = 1'b1; i_addr = 32'h101F; bmem_ready = 1'b1;
        #1;
        chk("i_issue_read", bmem_read, 1);
        chk("i_issue_addr", bmem_addr, 32'h1000);
        chk("i_issue_wr", bmem_write, 0);
        cyc();
        chk("i_one_cycle", bmem_read, 0);
        burst(32'h1000, 64'h0);
        chk("i_resp", i_resp, 1);
        chk("i_rdata", i_rdata, line(64'h0));
        chk("i_resp_block", bmem_read, 0);
        i_req = 1'b0;
        cyc();
        chk("i_resp_pulse", i_resp, 0);
        chk("i_rdata_hold", i_rdata, line(64'h0));
        // D write with stalling memory
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2040;
        d_wdata = {64'hAAAA_0003, 64'hAAAA_0002, 64'hAAAA_0001, 64'hAAAA_0000};
        for (int i = 0; i < 6; i++) begin
            bmem_ready = (rdy[i] != 0);
            #1;
            chk("w_write", bmem_write, 1);
            chk("w_addr", bmem_addr, 32'h2040);
            chk("w_wdata", bmem_wdata, 64'hAAAA_0000 + 64'(bt[i]));
            chk("w_noresp", d_resp, 0);
            if (bmem_ready && bmem_write) acc++;
            cyc();
        end
        bmem_ready = 1'b1;
        chk("w_beats", acc, 4);
        chk("w_dresp", d_resp, 1);
        chk("w_idle", bmem_write, 0);
        d_req = 1'b0; d_we = 1'b0;
        cyc();
        chk("w_dresp_pulse", d_resp, 0);
        // simultaneous requests after reset; D burst returns first
        rst = 1'b0; #2; rst = 1'b1;
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_addr = 32'h200;
        #1;
        chk("arb_first", bmem_addr, 32'h100);
        chk("arb_first_rd", bmem_read, 1);
        cyc();
        chk("arb_second", bmem_addr, 32'h200);
        chk("arb_second_rd", bmem_read, 1);
        cyc();
        chk("arb_none", bmem_read, 0);
        burst(32'h200, 64'hD0);
        chk("ooo_dresp", d_resp, 1);
        chk("ooo_iresp0", i_resp, 0);
        chk("ooo_drdata", d_rdata, line(64'hD0));
        d_req = 1'b0;
        burst(32'h100, 64'h10);
        chk("ooo_iresp", i_resp, 1);
        chk("ooo_dresp0", d_resp, 0);
        chk("ooo_irdata", i_rdata, line(64'h10));
        i_req = 1'b0;
        cyc();
        // both clients read the same line
        i_req = 1'b1; i_addr = 32'h300;
        d_req = 1'b1; d_addr = 32'h300;
        #1;
        chk("same_i_issue", bmem_read, 1);
        cyc();
        chk("same_d_issue", bmem_read, 1);
        cyc();
        burst(32'h300, 64'h30);
        chk("same_dresp", d_resp, 1);
        chk("same_iresp0", i_resp, 0);
        chk("same_drdata", d_rdata, line(64'h30));
        d_req = 1'b0;
        burst(32'h300, 64'h40);
        chk("same_iresp", i_resp, 1);
        chk("same_dresp0", d_resp, 0);
        chk("same_irdata", i_rdata, line(64'h40));
        i_req = 1'b0;
        cyc();
        // stray beat with nothing pending, then a clean burst
        bmem_rvalid = 1'b1; bmem_raddr = 32'h9999; bmem_rdata = 64'h55;
        cyc();
        bmem_rvalid = 1'b0;
        chk("stray_iresp", i_resp, 0);
        chk("stray_dresp", d_resp, 0);
        i_req = 1'b1; i_addr = 32'h500;
        cyc();
        burst(32'h500, 64'h50);
        chk("after_stray_resp", i_resp, 1);
        chk("after_stray_data", i_rdata, line(64'h50));
        i_req = 1'b0;
        cyc();
        // reset during write beat 2 and read beat 1
        i_req = 1'b1; i_addr = 32'h600;
        cyc();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h700;
        #1;
        chk("mid_w_issue", bmem_write, 1);
        cyc();
        bmem_rvalid = 1'b1; bmem_raddr = 32'h600; bmem_rdata = 64'h60;
        cyc();
        bmem_rdata = 64'h61;
        #1;
        chk("mid_w_beat2", bmem_wdata, 64'hAAAA_0002);
        #2 rst = 1'b0;
        #1;
        chk("arst_write", bmem_write, 0);
        chk("arst_read", bmem_read, 0);
        chk("arst_addr", bmem_addr, 0);
        chk("arst_wdata", bmem_wdata, 0);
        chk("arst_irdata", i_rdata, 0);
        chk("arst_drdata", d_rdata, 0);
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        cyc();
        rst = 1'b1;
        bmem_rdata = 64'h62;
        cyc();
        bmem_rdata = 64'h63;
        cyc();
        bmem_rvalid = 1'b0;
        chk("arst_stray_i", i_resp, 0);
        chk("arst_stray_d", d_resp, 0);
        cyc();
        chk("arst_stray_i2", i_resp, 0);
        i_req = 1'b1; i_addr = 32'h800;
        #1;
        chk("post_rst_read", bmem_read, 1);
        chk("post_rst_addr", bmem_addr, 32'h800);
        cyc();
        burst(32'h800, 64'h80);
        chk("post_rst_resp", i_resp, 1);
        chk("post_rst_data", i_rdata, line(64'h80));
        i_req = 1'b0;
        cyc();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bmem_line_adapter.md
# bmem_line_adapter

Line-level memory front end inside `cpu`, directly upstream of the banked burst DRAM interface (`bmem_*`). Arbitrates between the instruction cache (read-only) and the data cache (read/write) and issues 4-beat × 64-bit bursts. Reassembles out-of-order read bursts into 256-bit lines by matching `bmem_raddr`. Allows one outstanding read per client, so up to two reads are in flight.

## Interface
- `BEAT_W`, 64: bits per bmem beat.
- `BEATS`, 4: beats per line. Line width is `BEAT_W*BEATS` (256).
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock, reset is asynchronous and active-low (asserted when 0).
- `i_req`  in  1  I-cache line read request; held until `i_resp`.
- `i_addr`  in  32  I line address; bits [4:0] ignored and forced to 0 on issue.
- `i_resp`  out  1  one-cycle pulse; `i_rdata` valid this cycle.
- `i_rdata`  out  256  I line, beat k in bits [64k+63:64k].
- `d_req`, `d_we`, `d_addr[31:0]`, `d_wdata[255:0]`  in  D request, write-enable, line address, write line; held until `d_resp`.
- `d_resp`  out  1  one-cycle pulse (read data valid, or write complete).
- `d_rdata`  out  256  D line.
- `bmem_addr`  out  32; `bmem_read`, `bmem_write`  out  1; `bmem_wdata`  out  64.
- `bmem_ready`  in  1  memory accepts this cycle's read/write beat.
- `bmem_raddr`  in  32; `bmem_rdata`  in  64; `bmem_rvalid`  in  1.

## Operation
- Issue FSM states are IDLE and WR. The FSM has a 2-bit write-beat counter `wcnt`.
- IDLE eligibility:
  - A client is eligible if its `req` is high, it has no read pending, and its `resp` is not asserted this cycle.
  - If both clients are eligible, round-robin decides. `rr` names the client favoured next and toggles on every accepted issue. `rr` resets to I.
- Read issue:
  - The adapter drives `bmem_read=1` and `bmem_addr={addr[31:5],5'b0}` combinationally in IDLE.
  - The issue is accepted when `bmem_ready=1`. The adapter then sets the client's `pend` flag and latches its address.
  - If `bmem_ready=0`, the adapter re-arbitrates next cycle; nothing is latched.
- Write issue (D only):
  - In IDLE the adapter drives `bmem_write=1`, the line address, and `bmem_wdata` = beat 0.
  - Accepted with `bmem_ready` → WR, `wcnt=1`.
  - In WR, beat `wcnt` is presented with `bmem_write=1` on every cycle. `wcnt` advances only when `bmem_ready=1`. `bmem_addr` holds the line address.
  - When beat 3 is accepted → IDLE, and `d_resp` pulses next cycle.
- Read response:
  - The bmem protocol returns the 4 beats of a burst contiguously, in beat order, never interleaved with another burst.
  - On beat 0 (`rcnt==0`) the owner is chosen: D if `d_pend` and `bmem_raddr==d_addr_q`; else I if `i_pend` and `bmem_raddr==i_addr_q`; else the beat is dropped and `rcnt` is not advanced.
  - Beats 1–3 go to the latched owner regardless of `raddr`. Beat k is written into owner buffer slice k.
  - After beat 3, the owner's `pend` clears and `*_resp` pulses next cycle with the full line.
- Issue and response paths are independent: a write burst may proceed while read beats arrive.
- Reads of the same line by both clients are legal. D matches first; I matches the second burst.

## Timing
- Reset (async, `rst=0`):
  - `i_resp`, `d_resp`, `bmem_read` and `bmem_write` are 0.
  - `bmem_addr`, `bmem_wdata`, `i_rdata` and `d_rdata` are 0.
  - Both `pend` flags are 0, `rcnt=wcnt=0`, FSM is IDLE, `rr`=I.
  - Reset mid-burst aborts it. Subsequent stray `rvalid` beats are dropped (no owner).
- Read latency:
  - Issue is the same cycle as an eligible `req` when memory is ready.
  - `resp` is exactly 1 cycle after the 4th `rvalid` beat.
- Write latency: `d_resp` rises 4 cycles after `d_req` at the earliest (beats at cycles 0–3, resp at cycle 4).
- `*_rdata` holds its value until the next completion for that client.
- A `resp` cycle blocks re-acceptance of that client in the same cycle.

## Test plan
- I read of 0x1000, ready=1; memory returns beats 0x0..0x3 (value = beat index) → `bmem_read` for 1 cycle with addr 0x1000. `i_resp` 1 cycle after the last beat. `i_rdata` = {64'h3,64'h2,64'h1,64'h0}.
- D write of 0x2040, ready toggling 1,0,1,1,0,1 → exactly 4 accepted beats in order 0–3 at addr 0x2040. `d_resp` pulses once, 1 cycle after beat 3.
- I 0x100 and D 0x200 requested simultaneously after reset → I issued first, D next cycle. Memory returns the D burst first → `d_resp` precedes `i_resp`, data correctly routed.
- Both clients read 0x300 → D gets the first burst and I gets the second; each sees one resp.
- `rvalid` with raddr 0x9999 and nothing pending → no resp; `rcnt` stays 0. A following valid burst completes normally.
- Assert `rst=0` mid write beat 2 and mid read beat 1 → all outputs 0 immediately. After release, a new I read completes cleanly.
